// File: rtl/seq_pattern_gen.sv
// Bit-serial pattern transmitter: accepts {pattern, repeat, gap} over a
// valid/ready handshake and sends the pattern MSB-first on dout, one bit per
// clock, repeated with an optional idle gap between repetitions.
// All outputs are decoded from registered state, so no input reaches an
// output combinationally.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_repeat,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg,    state_next;
  logic [PAT_W-1:0] sreg_reg,     sreg_next;
  logic [PAT_W-1:0] pat_hold_reg, pat_hold_next;
  logic [CNT_W-1:0] rep_cnt_reg,  rep_cnt_next;
  logic [GAP_W-1:0] gap_len_reg,  gap_len_next;
  logic [GAP_W-1:0] gap_cnt_reg,  gap_cnt_next;
  logic [IDX_W-1:0] bit_idx_reg,  bit_idx_next;

  // State and datapath registers; reset returns everything to idle/zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sreg_reg     <= '0;
      pat_hold_reg <= '0;
      rep_cnt_reg  <= '0;
      gap_len_reg  <= '0;
      gap_cnt_reg  <= '0;
      bit_idx_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      sreg_reg     <= sreg_next;
      pat_hold_reg <= pat_hold_next;
      rep_cnt_reg  <= rep_cnt_next;
      gap_len_reg  <= gap_len_next;
      gap_cnt_reg  <= gap_cnt_next;
      bit_idx_reg  <= bit_idx_next;
    end
  end

  // Next-state and datapath sequencing; abort outranks normal sequencing.
  always_comb begin
    state_next    = state_reg;
    sreg_next     = sreg_reg;
    pat_hold_next = pat_hold_reg;
    rep_cnt_next  = rep_cnt_reg;
    gap_len_next  = gap_len_reg;
    gap_cnt_next  = gap_cnt_reg;
    bit_idx_next  = bit_idx_reg;

    unique case (state_reg)
      IDLE: begin
        // cfg_ready is 1 here, so cfg_valid alone completes the handshake.
        if (cfg_valid) begin
          sreg_next     = cfg_pattern;
          pat_hold_next = cfg_pattern;
          rep_cnt_next  = cfg_repeat;
          gap_len_next  = cfg_gap;
          bit_idx_next  = IDX_LAST;
          state_next    = (cfg_repeat == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          sreg_next    = {sreg_reg[PAT_W-2:0], 1'b0};
          bit_idx_next = bit_idx_reg - IDX_W'(1);
          if (bit_idx_reg == '0) begin
            rep_cnt_next = rep_cnt_reg - CNT_W'(1);
            if (rep_cnt_reg == CNT_W'(1)) begin
              state_next = DONE;
            end else if (gap_len_reg == '0) begin
              // Back-to-back repetition: reload without a bubble.
              sreg_next    = pat_hold_reg;
              bit_idx_next = IDX_LAST;
            end else begin
              gap_cnt_next = gap_len_reg;
              state_next   = GAP;
            end
          end
        end
      end

      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
          if (gap_cnt_reg == GAP_W'(1)) begin
            sreg_next    = pat_hold_reg;
            bit_idx_next = IDX_LAST;
            state_next   = SHIFT;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state and shift register.
  always_comb begin
    cfg_ready  = (state_reg == IDLE);
    dout_valid = (state_reg == SHIFT);
    dout       = (state_reg == SHIFT) ? sreg_reg[PAT_W-1] : 1'b0;
    busy       = (state_reg == SHIFT) || (state_reg == GAP);
    done       = (state_reg == DONE);
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed scenarios plus random
// transfers, each compared cycle by cycle against an expected trace built
// from the transfer rules (bits, gaps, done pulse, abort/reset truncation).
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_repeat;
  logic [GAP_W-1:0] cfg_gap;
  logic             abort;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_repeat (cfg_repeat),
    .cfg_gap    (cfg_gap),
    .abort      (abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Expected per-cycle output vector.
  typedef struct packed {
    logic v;
    logic d;
    logic b;
    logic dn;
    logic rdy;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic bits_q[$];

  function automatic exp_t mk(input logic v, input logic d, input logic b,
                              input logic dn, input logic rdy);
    exp_t e;
    e.v = v; e.d = d; e.b = b; e.dn = dn; e.rdy = rdy;
    return e;
  endfunction

  task automatic check(input string tag, input int cyc,
                       input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input int cyc, input exp_t e);
    check({name, ".dout_valid"}, cyc, 32'(dout_valid), 32'(e.v));
    check({name, ".dout"},       cyc, 32'(dout),       32'(e.d));
    check({name, ".busy"},       cyc, 32'(busy),       32'(e.b));
    check({name, ".done"},       cyc, 32'(done),       32'(e.dn));
    check({name, ".cfg_ready"},  cyc, 32'(cfg_ready),  32'(e.rdy));
  endtask

  task automatic randomize_cfg();
    cfg_pattern = PAT_W'($urandom);
    cfg_repeat  = CNT_W'($urandom);
    cfg_gap     = GAP_W'($urandom);
  endtask

  // One transfer from an IDLE sample point back to an IDLE sample point.
  // stop_at > 0 applies abort (or rst) during that cycle of the transfer.
  // hold keeps cfg_valid high with changing fields throughout.
  task automatic run_transfer(input string name, input logic [PAT_W-1:0] pat,
                              input int r, input int g, input int stop_in,
                              input bit use_rst, input bit hold);
    exp_t e;
    int   n;
    int   stop_at;
    int   busy_seen;
    exp_t idle_e;
    idle_e    = mk(0, 0, 0, 0, 1);
    stop_at   = stop_in;
    busy_seen = 0;
    exp_q.delete();
    bits_q.delete();

    // Expected trace: R repetitions MSB-first, G idle busy cycles between
    // repetitions, one done cycle, then idle.
    for (int i = 0; i < r; i++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(mk(1, pat[b], 1, 0, 0));
      if (i < r - 1) for (int j = 0; j < g; j++) exp_q.push_back(mk(0, 0, 1, 0, 0));
    end
    exp_q.push_back(mk(0, 0, 0, 1, 0));
    exp_q.push_back(idle_e);

    // Abort/reset in a busy cycle: idle from the next cycle, no done pulse.
    if (stop_at > 0 && stop_at <= exp_q.size() && exp_q[stop_at-1].b) begin
      while (exp_q.size() > stop_at) void'(exp_q.pop_back());
      exp_q.push_back(idle_e);
      exp_q.push_back(idle_e);
    end else begin
      stop_at = 0;
    end

    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_repeat  = CNT_W'(r);
    cfg_gap     = GAP_W'(g);
    check({name, ".ready_at_accept"}, 0, 32'(cfg_ready), 32'(1));
    tick();
    if (hold) randomize_cfg();
    else begin
      cfg_valid = 1'b0;
      randomize_cfg();
    end

    n = exp_q.size();
    for (int idx = 1; idx <= n; idx++) begin
      if (idx > 1) tick();
      e = exp_q[idx-1];
      check_outputs(name, idx, e);
      if (busy) busy_seen++;
      if (dout_valid) bits_q.push_back(dout);
      if (stop_at > 0 && idx == stop_at + 1) begin
        abort = 1'b0;
        rst   = 1'b0;
      end
      if (stop_at > 0 && idx == stop_at) begin
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        cfg_valid = 1'b0;
      end else if (hold && stop_at == 0 && idx < n) begin
        randomize_cfg();
      end
    end

    if (stop_at == 0) begin
      check({name, ".busy_cycles"}, n, 32'(busy_seen),
            32'((r == 0) ? 0 : r * PAT_W + (r - 1) * g));
      check({name, ".bit_count"}, n, 32'(bits_q.size()), 32'(r * PAT_W));
    end
    $display("[TB] %s pat=%b rep=%0d gap=%0d stop=%0d rst=%0d hold=%0d cycles=%0d",
             name, pat, r, g, stop_at, use_rst, hold, n);
  endtask

  // Count windows of the serial stream that match a PAT_W-bit pattern.
  function automatic int count_matches(input logic [PAT_W-1:0] pat);
    logic [PAT_W-1:0] win;
    int c;
    int k;
    win = '0;
    c   = 0;
    k   = 0;
    foreach (bits_q[i]) begin
      win = {win[PAT_W-2:0], bits_q[i]};
      k++;
      if (k >= PAT_W && win == pat) c++;
    end
    return c;
  endfunction

  // Hard bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int g;
    int stop;
    bit hold;
    bit use_rst;
    logic [PAT_W-1:0] pat;

    rst         = 1'b1;
    abort       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_pattern = '0;
    cfg_repeat  = '0;
    cfg_gap     = '0;
    repeat (3) tick();
    check_outputs("reset", 0, mk(0, 0, 0, 0, 1));
    rst = 1'b0;
    tick();
    check_outputs("post_reset", 0, mk(0, 0, 0, 0, 1));

    run_transfer("single",    4'b1011, 1, 0, 0, 0, 0);
    run_transfer("b2b3",      4'b1011, 3, 0, 0, 0, 0);
    check("b2b3.detector_hits", 0, 32'(count_matches(4'b1011)), 32'(3));
    run_transfer("gap3",      4'b1011, 2, 3, 0, 0, 0);
    run_transfer("rep0",      4'b1011, 0, 5, 0, 0, 0);
    run_transfer("abort",     4'b1011, 5, 2, PAT_W + 2 + 2, 0, 0);
    run_transfer("abort_b2b", 4'b1011, 5, 0, PAT_W + 2, 0, 0);
    run_transfer("reset_mid", 4'b1011, 5, 0, PAT_W + 2, 1, 0);
    run_transfer("hold",      4'b1011, 2, 1, 0, 0, 1);
    run_transfer("after_hold",4'b0110, 2, 0, 0, 0, 0);
    run_transfer("gap_max",   4'b1001, 3, 15, 0, 0, 0);
    run_transfer("rep_max",   4'b1101, 255, 0, 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      pat     = PAT_W'($urandom);
      r       = int'($urandom_range(0, 6));
      g       = int'($urandom_range(0, 15));
      hold    = ($urandom_range(0, 3) == 0);
      use_rst = ($urandom_range(0, 1) == 1);
      stop    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      run_transfer($sformatf("rand%0d", t), pat, r, g, stop, use_rst, hold);
    end

    cfg_valid = 1'b0;
    abort     = 1'b0;
    tick();
    check_outputs("final_idle", 0, mk(0, 0, 0, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
